// File: rtl/gerador_tom.sv
// rtl/gerador_tom.sv - note-code to fixed-length square-wave buzzer with post-note gap; `GERADOR_TOM_RETRIGGER_EN adds restart-while-busy
module gerador_tom #(
    parameter int unsigned CLOCK_FREQ  = 50000000,
    parameter int unsigned NOTE_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES  = 2500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] nota,
    input  logic       enable,
    output logic       buzzer,
    output logic       tocando,
    output logic       fim_nota,
    output logic [2:0] db_nota
);

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] TOCANDO = 2'd1;
    localparam logic [1:0] PAUSA   = 2'd2;

    localparam logic [31:0] HALF_1 = 32'(CLOCK_FREQ / (2 * 262));
    localparam logic [31:0] HALF_2 = 32'(CLOCK_FREQ / (2 * 294));
    localparam logic [31:0] HALF_3 = 32'(CLOCK_FREQ / (2 * 330));
    localparam logic [31:0] HALF_4 = 32'(CLOCK_FREQ / (2 * 349));
    localparam logic [31:0] HALF_5 = 32'(CLOCK_FREQ / (2 * 392));
    localparam logic [31:0] HALF_6 = 32'(CLOCK_FREQ / (2 * 440));
    localparam logic [31:0] HALF_7 = 32'(CLOCK_FREQ / (2 * 494));

    localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYCLES - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
    localparam bit          NO_GAP    = (GAP_CYCLES == 0);

    function automatic logic [31:0] half_of(input logic [2:0] n);
        case (n)
            3'd1:    return HALF_1;
            3'd2:    return HALF_2;
            3'd3:    return HALF_3;
            3'd4:    return HALF_4;
            3'd5:    return HALF_5;
            3'd6:    return HALF_6;
            3'd7:    return HALF_7;
            default: return 32'd1;
        endcase
    endfunction

    logic [1:0]  state_q, state_d;
    logic [2:0]  nota_q, nota_d;
    logic [31:0] half_q, half_d;
    logic [31:0] div_q, div_d;
    logic [31:0] dur_q, dur_d;
    logic [31:0] gap_q, gap_d;
    logic        buzzer_q, buzzer_d;
    logic        fim_q, fim_d;
    logic        start;
    logic        accept;

    assign start = enable && (nota != 3'd0);

    always_comb begin
        state_d  = state_q;
        nota_d   = nota_q;
        half_d   = half_q;
        div_d    = div_q;
        dur_d    = dur_q;
        gap_d    = gap_q;
        buzzer_d = buzzer_q;
        fim_d    = 1'b0;
        accept   = 1'b0;
        case (state_q)
            OCIOSO: accept = start;
            TOCANDO: begin
                dur_d = dur_q + 32'd1;
                if (div_q == half_q - 32'd1) begin
                    buzzer_d = ~buzzer_q;
                    div_d    = 32'd0;
                end else begin
                    div_d = div_q + 32'd1;
                end
                // Note end overrides a coincident divider toggle.
                if (dur_q == NOTE_LAST) begin
                    buzzer_d = 1'b0;
                    fim_d    = 1'b1;
                    div_d    = 32'd0;
                    gap_d    = 32'd0;
                    if (NO_GAP) begin
                        state_d = OCIOSO;
                        nota_d  = 3'd0;
                        accept  = start;
                    end else begin
                        state_d = PAUSA;
                    end
                end
            end
            PAUSA: begin
                buzzer_d = 1'b0;
                // The edge that ends the gap also serves as the idle edge for a held enable.
                if (gap_q == GAP_LAST) begin
                    state_d = OCIOSO;
                    nota_d  = 3'd0;
                    accept  = start;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            default: state_d = OCIOSO;
        endcase
`ifdef GERADOR_TOM_RETRIGGER_EN
        if (state_q != OCIOSO && start) begin
            accept = 1'b1;
            fim_d  = 1'b0;
        end else if (state_q == TOCANDO && enable) begin
            state_d  = OCIOSO;
            nota_d   = 3'd0;
            buzzer_d = 1'b0;
            div_d    = 32'd0;
            fim_d    = 1'b0;
        end
`endif
        if (accept) begin
            state_d  = TOCANDO;
            nota_d   = nota;
            half_d   = half_of(nota);
            buzzer_d = 1'b1;
            div_d    = 32'd0;
            dur_d    = 32'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= OCIOSO;
            nota_q   <= 3'd0;
            half_q   <= 32'd0;
            div_q    <= 32'd0;
            dur_q    <= 32'd0;
            gap_q    <= 32'd0;
            buzzer_q <= 1'b0;
            fim_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            nota_q   <= nota_d;
            half_q   <= half_d;
            div_q    <= div_d;
            dur_q    <= dur_d;
            gap_q    <= gap_d;
            buzzer_q <= buzzer_d;
            fim_q    <= fim_d;
        end
    end

    assign buzzer   = buzzer_q;
    assign tocando  = (state_q != OCIOSO);
    assign fim_nota = fim_q;
    assign db_nota  = nota_q;

endmodule
